// File: rtl/alarm_controller.sv
// Arming/alarm sequencer: turns the sensor alert level into exit delay, armed
// surveillance, entry delay and a bounded siren period, timed by an enable tick.
module alarm_controller #(
    parameter int unsigned EXIT_DELAY  = 30,
    parameter int unsigned ENTRY_DELAY = 15,
    parameter int unsigned SIREN_TIME  = 120,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             alert,
    input  logic             arm,
    input  logic             disarm,
    output logic [2:0]       state,
    output logic             armed,
    output logic             siren,
    output logic [CNT_W-1:0] countdown,
    output logic             alarm_event
);

    localparam int unsigned ST_W = 3;

    localparam logic [CNT_W-1:0] EXIT_LD  = CNT_W'(EXIT_DELAY);
    localparam logic [CNT_W-1:0] ENTRY_LD = CNT_W'(ENTRY_DELAY);
    localparam logic [CNT_W-1:0] SIREN_LD = CNT_W'(SIREN_TIME);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    typedef enum logic [ST_W-1:0] {
        ST_DISARMED   = 3'd0,
        ST_EXIT_WAIT  = 3'd1,
        ST_ARMED      = 3'd2,
        ST_ENTRY_WAIT = 3'd3,
        ST_ALARM      = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             armed_q, armed_d;
    logic             siren_q, siren_d;
    logic             event_q, event_d;

    // A timed state expires on the tick that sees count==1; <=1 also covers a
    // zero count so the counter can never wrap.
    logic             expire_c;
    logic [CNT_W-1:0] cnt_dec_c;

    assign expire_c  = tick && (cnt_q <= CNT_ONE);
    assign cnt_dec_c = cnt_q - CNT_ONE;

    // State, counter and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_DISARMED;
            cnt_q   <= CNT_ZERO;
            armed_q <= 1'b0;
            siren_q <= 1'b0;
            event_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
            siren_q <= siren_d;
            event_q <= event_d;
        end
    end

    // Next-state and next-output logic; disarm outranks expiry/alert, which outrank arm
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        armed_d = 1'b0;
        siren_d = 1'b0;
        event_d = 1'b0;

        if (disarm) begin
            state_d = ST_DISARMED;
            cnt_d   = CNT_ZERO;
        end else begin
            unique case (state_q)
                ST_DISARMED: begin
                    cnt_d = CNT_ZERO;
                    if (arm) begin
                        state_d = ST_EXIT_WAIT;
                        cnt_d   = EXIT_LD;
                    end
                end
                ST_EXIT_WAIT: begin
                    if (expire_c) begin
                        state_d = ST_ARMED;
                        cnt_d   = CNT_ZERO;
                    end else if (tick) begin
                        cnt_d = cnt_dec_c;
                    end
                end
                ST_ARMED: begin
                    cnt_d = CNT_ZERO;
                    if (alert) begin
                        state_d = ST_ENTRY_WAIT;
                        cnt_d   = ENTRY_LD;
                    end
                end
                ST_ENTRY_WAIT: begin
                    if (expire_c) begin
                        state_d = ST_ALARM;
                        cnt_d   = SIREN_LD;
                    end else if (tick) begin
                        cnt_d = cnt_dec_c;
                    end
                end
                ST_ALARM: begin
                    // Always return via ARMED so a held alert restarts the entry delay
                    if (expire_c) begin
                        state_d = ST_ARMED;
                        cnt_d   = CNT_ZERO;
                    end else if (tick) begin
                        cnt_d = cnt_dec_c;
                    end
                end
                default: begin
                    state_d = ST_DISARMED;
                    cnt_d   = CNT_ZERO;
                end
            endcase
        end

        armed_d = (state_d == ST_ARMED) || (state_d == ST_ENTRY_WAIT) ||
                  (state_d == ST_ALARM);
        siren_d = (state_d == ST_ALARM);
        event_d = (state_d == ST_ALARM) && (state_q != ST_ALARM);
    end

    assign state       = state_q;
    assign armed       = armed_q;
    assign siren       = siren_q;
    assign countdown   = cnt_q;
    assign alarm_event = event_q;

endmodule

// File: tb/tb_alarm_controller.sv
// Directed bench for alarm_controller: a default-parameter instance and a
// short-delay instance share stimulus; each task checks one scenario.
module tb_alarm_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tick = 1'b0;
    logic alert = 1'b0;
    logic arm = 1'b0;
    logic disarm = 1'b0;

    logic [2:0] d_state, s_state;
    logic       d_armed, s_armed, d_siren, s_siren, d_event, s_event;
    logic [7:0] d_cnt, s_cnt;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [13:0] d_obs, s_obs, exp_v;
    assign d_obs = {d_state, d_armed, d_siren, d_event, d_cnt};
    assign s_obs = {s_state, s_armed, s_siren, s_event, s_cnt};

    always #5 clk = ~clk;

    alarm_controller u_dflt (
        .clk(clk), .rst(rst), .tick(tick), .alert(alert), .arm(arm), .disarm(disarm),
        .state(d_state), .armed(d_armed), .siren(d_siren), .countdown(d_cnt),
        .alarm_event(d_event)
    );

    alarm_controller #(.EXIT_DELAY(3), .ENTRY_DELAY(2), .SIREN_TIME(4), .CNT_W(8)) u_small (
        .clk(clk), .rst(rst), .tick(tick), .alert(alert), .arm(arm), .disarm(disarm),
        .state(s_state), .armed(s_armed), .siren(s_siren), .countdown(s_cnt),
        .alarm_event(s_event)
    );

    // Apply single-cycle requests for one clock, then sample 1 ns after the edge
    task automatic step(input logic a, input logic d, input logic t);
        arm = a; disarm = d; tick = t;
        @(posedge clk); #1;
        arm = 1'b0; disarm = 1'b0; tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        alert = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // obs layout: {state[2:0], armed, siren, alarm_event, countdown[7:0]}
    task automatic test_reset();
        do_reset();
        exp_v = {3'd0, 1'b0, 1'b0, 1'b0, 8'd0};
        total_cnt++;
        if (d_obs !== exp_v) $display("FAIL reset_dflt: got %h want %h", d_obs, exp_v);
        else pass_cnt++;
        total_cnt++;
        if (s_obs !== exp_v) $display("FAIL reset_small: got %h want %h", s_obs, exp_v);
        else pass_cnt++;
        step(1'b0, 1'b0, 1'b0);
        alert = 1'b1;
        step(1'b0, 1'b0, 1'b1);
        alert = 1'b0;
        total_cnt++;
        if (d_obs !== exp_v) $display("FAIL disarmed_ignores_alert: got %h want %h", d_obs, exp_v);
        else pass_cnt++;
    endtask

    task automatic test_arm_exit();
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        exp_v = {3'd1, 1'b0, 1'b0, 1'b0, 8'd30};
        total_cnt++;
        if (d_obs !== exp_v) $display("FAIL arm_load: got %h want %h", d_obs, exp_v);
        else pass_cnt++;
        ticks(29);
        exp_v = {3'd1, 1'b0, 1'b0, 1'b0, 8'd1};
        total_cnt++;
        if (d_obs !== exp_v) $display("FAIL exit_29_ticks: got %h want %h", d_obs, exp_v);
        else pass_cnt++;
        ticks(1);
        exp_v = {3'd2, 1'b1, 1'b0, 1'b0, 8'd0};
        total_cnt++;
        if (d_obs !== exp_v) $display("FAIL exit_to_armed: got %h want %h", d_obs, exp_v);
        else pass_cnt++;
        ticks(2);
        total_cnt++;
        if (d_obs !== exp_v) $display("FAIL armed_tick_no_effect: got %h want %h", d_obs, exp_v);
        else pass_cnt++;
    endtask

    task automatic test_ignored_arm();
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        ticks(25);
        step(1'b1, 1'b0, 1'b0);
        exp_v = {3'd1, 1'b0, 1'b0, 1'b0, 8'd5};
        total_cnt++;
        if (d_obs !== exp_v) $display("FAIL arm_in_exit_no_reload: got %h want %h", d_obs, exp_v);
        else pass_cnt++;
        ticks(1);
        exp_v = {3'd1, 1'b0, 1'b0, 1'b0, 8'd4};
        total_cnt++;
        if (d_obs !== exp_v) $display("FAIL exit_continues: got %h want %h", d_obs, exp_v);
        else pass_cnt++;
    endtask

    task automatic test_exit_immunity();
        do_reset();
        alert = 1'b1;
        step(1'b1, 1'b0, 1'b1);
        exp_v = {3'd1, 1'b0, 1'b0, 1'b0, 8'd3};
        total_cnt++;
        if (s_obs !== exp_v) $display("FAIL load_beats_tick: got %h want %h", s_obs, exp_v);
        else pass_cnt++;
        ticks(3);
        exp_v = {3'd2, 1'b1, 1'b0, 1'b0, 8'd0};
        total_cnt++;
        if (s_obs !== exp_v) $display("FAIL exit_immune_armed: got %h want %h", s_obs, exp_v);
        else pass_cnt++;
        step(1'b0, 1'b0, 1'b0);
        exp_v = {3'd3, 1'b1, 1'b0, 1'b0, 8'd2};
        total_cnt++;
        if (s_obs !== exp_v) $display("FAIL alert_to_entry: got %h want %h", s_obs, exp_v);
        else pass_cnt++;
        alert = 1'b0;
    endtask

    task automatic test_full_alarm();
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        ticks(3);
        alert = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        alert = 1'b0;
        ticks(1);
        exp_v = {3'd3, 1'b1, 1'b0, 1'b0, 8'd1};
        total_cnt++;
        if (s_obs !== exp_v) $display("FAIL entry_no_cancel: got %h want %h", s_obs, exp_v);
        else pass_cnt++;
        ticks(1);
        exp_v = {3'd4, 1'b1, 1'b1, 1'b1, 8'd4};
        total_cnt++;
        if (s_obs !== exp_v) $display("FAIL alarm_entry: got %h want %h", s_obs, exp_v);
        else pass_cnt++;
        step(1'b0, 1'b0, 1'b0);
        exp_v = {3'd4, 1'b1, 1'b1, 1'b0, 8'd4};
        total_cnt++;
        if (s_obs !== exp_v) $display("FAIL event_one_cycle: got %h want %h", s_obs, exp_v);
        else pass_cnt++;
        ticks(3);
        exp_v = {3'd4, 1'b1, 1'b1, 1'b0, 8'd1};
        total_cnt++;
        if (s_obs !== exp_v) $display("FAIL siren_count: got %h want %h", s_obs, exp_v);
        else pass_cnt++;
        alert = 1'b1;
        ticks(1);
        exp_v = {3'd2, 1'b1, 1'b0, 1'b0, 8'd0};
        total_cnt++;
        if (s_obs !== exp_v) $display("FAIL siren_end_armed: got %h want %h", s_obs, exp_v);
        else pass_cnt++;
        step(1'b0, 1'b0, 1'b0);
        exp_v = {3'd3, 1'b1, 1'b0, 1'b0, 8'd2};
        total_cnt++;
        if (s_obs !== exp_v) $display("FAIL held_alert_reentry: got %h want %h", s_obs, exp_v);
        else pass_cnt++;
        alert = 1'b0;
    endtask

    task automatic test_disarm_priority();
        do_reset();
        step(1'b1, 1'b1, 1'b0);
        exp_v = {3'd0, 1'b0, 1'b0, 1'b0, 8'd0};
        total_cnt++;
        if (s_obs !== exp_v) $display("FAIL arm_disarm_same_cycle: got %h want %h", s_obs, exp_v);
        else pass_cnt++;
        step(1'b1, 1'b0, 1'b0);
        ticks(3);
        alert = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        alert = 1'b0;
        ticks(1);
        step(1'b0, 1'b1, 1'b1);
        total_cnt++;
        if (s_obs !== exp_v) $display("FAIL disarm_beats_expiry: got %h want %h", s_obs, exp_v);
        else pass_cnt++;
        step(1'b0, 1'b0, 1'b1);
        total_cnt++;
        if (s_obs !== exp_v) $display("FAIL no_late_siren: got %h want %h", s_obs, exp_v);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        ticks(3);
        alert = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        alert = 1'b0;
        ticks(2);
        total_cnt++;
        if (s_siren !== 1'b1) $display("FAIL pre_reset_siren: got %b want 1", s_siren);
        else pass_cnt++;
        #2 rst = 1'b1;
        #1;
        exp_v = {3'd0, 1'b0, 1'b0, 1'b0, 8'd0};
        total_cnt++;
        if (s_obs !== exp_v) $display("FAIL async_reset_alarm: got %h want %h", s_obs, exp_v);
        else pass_cnt++;
        @(posedge clk); #1;
        rst = 1'b0;
        step(1'b0, 1'b0, 1'b1);
        total_cnt++;
        if (s_obs !== exp_v) $display("FAIL post_reset_quiet: got %h want %h", s_obs, exp_v);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_arm_exit();
        test_ignored_arm();
        test_exit_immunity();
        test_full_alarm();
        test_disarm_priority();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
